riscv_mc_control: RTL and testbench

Multi-cycle main controller for the RV32I datapath. It decodes the instruction register opcode and steps the shared datapath (PC, IR, ALU, register file, unified memory port) through fetch/decode/execute/memory/writeback states. It drives the 2-bit `alu_op` consumed by `alu_control` (00 add, 01 sub/branch, 10 R-type funct decode, 11 I-type funct decode), handshakes with a variable-latency memory, and halts on illegal opcodes or memory timeout.

---
 rtl/riscv_mc_control.sv | 195 +++++++++++++++++++
 tb/tb_riscv_mc_control.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_control.sv
// Multi-cycle RV32I main controller: steps PC/IR/ALU/regfile/memory through fetch..writeback.
// Strobes decode from the state register; memory waits are bounded by a timeout that halts the core.
module riscv_mc_control #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        retired,
  output logic        illegal,
  output logic        mem_timeout,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd15
  } state_t;

  state_t     st;
  state_t     nxt;
  logic [7:0] wait_cnt;
  logic       illegal_q;
  logic       timeout_q;
  logic       in_wait;
  logic       wait_expired;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_inst_bits;

  assign opcode           = inst[6:0];
  assign funct3           = inst[14:12];
  assign unused_inst_bits = ^{inst[31:15], inst[11:7]};

  assign in_wait      = (st == S_FETCH) || (st == S_MEM_RD) || (st == S_MEM_WR);
  // A ready arriving on the final allowed wait cycle still wins over the timeout.
  assign wait_expired = in_wait && !mem_ready && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    nxt = st;
    case (st)
      S_FETCH:    if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          7'b0110011: nxt = S_EXEC_R;
          7'b0010011: nxt = S_EXEC_I;
          7'b0000011,
          7'b0100011: nxt = S_MEM_ADDR;
          7'b1100011: nxt = (funct3 == 3'b000) ? S_BRANCH : S_HALT;
          7'b1101111: nxt = S_JAL;
          default:    nxt = S_HALT;
        endcase
      end
      S_EXEC_R,
      S_EXEC_I:   nxt = S_WB_ALU;
      S_MEM_ADDR: nxt = opcode[5] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) nxt = S_WB_MEM;
      S_MEM_WR:   if (mem_ready) nxt = S_FETCH;
      S_WB_ALU,
      S_WB_MEM,
      S_BRANCH,
      S_JAL:      nxt = S_FETCH;
      S_HALT:     nxt = S_HALT;
      default:    nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= S_FETCH;
      wait_cnt  <= 8'd0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else if (wait_expired) begin
      st        <= S_HALT;
      wait_cnt  <= 8'd0;
      timeout_q <= 1'b1;
    end else begin
      st <= nxt;
      if (!in_wait || mem_ready || nxt != st)
        wait_cnt <= 8'd0;
      else
        wait_cnt <= wait_cnt + 8'd1;
      if (st == S_DECODE && nxt == S_HALT)
        illegal_q <= 1'b1;
    end
  end

  // Reset forces every output low in the reset cycle itself, even mid-access.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    reg_write   = 1'b0;
    wb_sel      = 2'b00;
    retired     = 1'b0;
    illegal     = 1'b0;
    mem_timeout = 1'b0;
    state       = 4'd0;
    if (!reset) begin
      illegal     = illegal_q;
      mem_timeout = timeout_q;
      state       = st;
      case (st)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b10;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        S_EXEC_R: begin
          alu_src_a = 2'b01;
          alu_op    = 2'b10;
        end
        S_EXEC_I: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          alu_op    = 2'b11;
        end
        S_MEM_ADDR: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          retired = mem_ready;
        end
        S_WB_ALU: begin
          reg_write = 1'b1;
          retired   = 1'b1;
        end
        S_WB_MEM: begin
          reg_write = 1'b1;
          wb_sel    = 2'b01;
          retired   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 2'b01;
          alu_op    = 2'b01;
          pc_src    = 2'b01;
          pc_write  = zero;
          retired   = 1'b1;
        end
        S_JAL: begin
          reg_write = 1'b1;
          wb_sel    = 2'b10;
          pc_write  = 1'b1;
          pc_src    = 2'b01;
          retired   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mc_control.sv
// Directed bench for riscv_mc_control: per-cycle expected output vectors per scenario.
module tb_riscv_mc_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write, reg_write, retired, illegal, mem_timeout;
  logic [1:0]  pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;
  logic [3:0]  state;

  int compared = 0;
  int failed   = 0;

  riscv_mc_control #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset(reset), .inst(inst), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel), .retired(retired),
    .illegal(illegal), .mem_timeout(mem_timeout), .state(state)
  );

  always #5 clk = ~clk;

  // {mem_req,mem_we,iord,ir_write,pc_write,pc_src,alu_src_a,alu_src_b,alu_op,reg_write,wb_sel,retired,illegal,mem_timeout,state}
  logic [22:0] outs;
  assign outs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                 alu_op, reg_write, wb_sel, retired, illegal, mem_timeout, state};

  localparam logic [22:0] ZERO   = 23'd0;
  localparam logic [22:0] F_WAIT = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,4'd0};
  localparam logic [22:0] F_RDY  = {1'b1,1'b0,1'b0,1'b1,1'b1,2'b00,2'b00,2'b10,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,4'd0};
  localparam logic [22:0] DEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,4'd1};
  localparam logic [22:0] EXR    = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b00,2'b10,1'b0,2'b00,1'b0,1'b0,1'b0,4'd2};
  localparam logic [22:0] EXI    = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b11,1'b0,2'b00,1'b0,1'b0,1'b0,4'd3};
  localparam logic [22:0] MADDR  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,4'd4};
  localparam logic [22:0] MRD    = {1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,4'd5};
  localparam logic [22:0] MWR_W  = {1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,4'd6};
  localparam logic [22:0] MWR_R  = {1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,2'b00,1'b1,1'b0,1'b0,4'd6};
  localparam logic [22:0] WBA    = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b1,2'b00,1'b1,1'b0,1'b0,4'd7};
  localparam logic [22:0] WBM    = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b1,2'b01,1'b1,1'b0,1'b0,4'd8};
  localparam logic [22:0] BR_T   = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b01,2'b00,2'b01,1'b0,2'b00,1'b1,1'b0,1'b0,4'd9};
  localparam logic [22:0] BR_N   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,2'b01,1'b0,2'b00,1'b1,1'b0,1'b0,4'd9};
  localparam logic [22:0] JALS   = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,2'b00,2'b00,1'b1,2'b10,1'b1,1'b0,1'b0,4'd10};
  localparam logic [22:0] HLT    = {19'd0, 4'd15};
  localparam logic [22:0] ILL    = 23'h000020;
  localparam logic [22:0] TO     = 23'h000010;

  // Called at posedge+1; leaves the DUT in FETCH at posedge+1.
  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    #2;
    compared++;
    if (outs !== ZERO) begin failed++; $display("FAIL reset_hold: got %h want %h", outs, ZERO); end
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ready = 1'b0;
    #2;
    compared++;
    if (outs !== F_WAIT) begin failed++; $display("FAIL reset_first_fetch: got %h want %h", outs, F_WAIT); end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    logic [22:0] e [5];
    e = '{F_RDY, DEC, EXR, WBA, F_RDY};
    inst = 32'h002081B3; zero = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1; #2;
      compared++;
      if (outs !== e[i]) begin failed++; $display("FAIL rtype[%0d]: got %h want %h", i, outs, e[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_itype();
    logic [22:0] e [4];
    e = '{F_RDY, DEC, EXI, WBA};
    inst = 32'h00108093; zero = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; #2;
      compared++;
      if (outs !== e[i]) begin failed++; $display("FAIL itype[%0d]: got %h want %h", i, outs, e[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_wait();
    logic [22:0] e [8];
    logic [7:0]  rdy;
    e = '{F_RDY, DEC, MADDR, MRD, MRD, MRD, WBM, F_WAIT};
    rdy = 8'b0110_0111;  // bit i = mem_ready in cycle i
    inst = 32'h0000A103; zero = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i]; #2;
      compared++;
      if (outs !== e[i]) begin failed++; $display("FAIL load[%0d]: got %h want %h", i, outs, e[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [22:0] e [4];
    for (int z = 0; z < 2; z++) begin
      e = '{F_RDY, DEC, (z == 1) ? BR_T : BR_N, F_RDY};
      inst = 32'h00208463; zero = (z == 1);
      do_reset();
      for (int i = 0; i < 4; i++) begin
        mem_ready = 1'b1; #2;
        compared++;
        if (outs !== e[i]) begin failed++; $display("FAIL beq_z%0d[%0d]: got %h want %h", z, i, outs, e[i]); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_illegal();
    logic [22:0] e [7];
    logic [31:0] bad [2];
    bad = '{32'h0000007F, 32'h00209463};  // unknown opcode; branch with funct3=001
    e = '{F_RDY, DEC, HLT | ILL, HLT | ILL, HLT | ILL, ZERO, F_WAIT};
    for (int k = 0; k < 2; k++) begin
      inst = bad[k]; zero = 1'b1;
      do_reset();
      for (int i = 0; i < 7; i++) begin
        mem_ready = (i != 6);
        reset = (i == 5);
        #2;
        compared++;
        if (outs !== e[i]) begin failed++; $display("FAIL illegal%0d[%0d]: got %h want %h", k, i, outs, e[i]); end
        @(posedge clk); #1;
      end
      reset = 1'b0;
    end
  endtask

  task automatic test_timeout();
    inst = 32'h002081B3; zero = 1'b0;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      mem_ready = 1'b0; #2;
      compared++;
      if (outs !== F_WAIT) begin failed++; $display("FAIL timeout_wait[%0d]: got %h want %h", i, outs, F_WAIT); end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2); #2;
      compared++;
      if (outs !== (HLT | TO)) begin failed++; $display("FAIL timeout_halt[%0d]: got %h want %h", i, outs, HLT | TO); end
      @(posedge clk); #1;
    end
    do_reset();
    mem_ready = 1'b0; #2;
    compared++;
    if (outs !== F_WAIT) begin failed++; $display("FAIL timeout_cleared: got %h want %h", outs, F_WAIT); end
    @(posedge clk); #1;
  endtask

  task automatic test_no_timeout();
    inst = 32'h002081B3; zero = 1'b0;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      mem_ready = 1'b0; #2;
      @(posedge clk); #1;
    end
    mem_ready = 1'b1; #2;
    compared++;
    if (outs !== F_RDY) begin failed++; $display("FAIL edge_ready_fetch: got %h want %h", outs, F_RDY); end
    @(posedge clk); #1;
    mem_ready = 1'b0; #2;
    compared++;
    if (outs !== DEC) begin failed++; $display("FAIL edge_ready_decode: got %h want %h", outs, DEC); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_write();
    logic [22:0] e [7];
    logic [6:0]  rdy;
    e = '{F_RDY, DEC, MADDR, MWR_W, MWR_W, ZERO, F_WAIT};
    rdy = 7'b010_0111;
    inst = 32'h0020A023; zero = 1'b0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy[i];
      reset = (i == 5);
      #2;
      compared++;
      if (outs !== e[i]) begin failed++; $display("FAIL reset_mid_wr[%0d]: got %h want %h", i, outs, e[i]); end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [22:0] e [12];
    logic [31:0] iv [12];
    e  = '{F_RDY, DEC, EXR, WBA, F_RDY, DEC, MADDR, MWR_R, F_RDY, DEC, JALS, F_RDY};
    iv = '{32'h002081B3, 32'h002081B3, 32'h002081B3, 32'h002081B3,
           32'h0020A023, 32'h0020A023, 32'h0020A023, 32'h0020A023,
           32'h008000EF, 32'h008000EF, 32'h008000EF, 32'h002081B3};
    zero = 1'b0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      inst = iv[i];
      mem_ready = 1'b1; #2;
      compared++;
      if (outs !== e[i]) begin failed++; $display("FAIL b2b[%0d]: got %h want %h", i, outs, e[i]); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    inst = 32'h0;
    zero = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_itype();
    test_load_wait();
    test_branch();
    test_illegal();
    test_timeout();
    test_no_timeout();
    test_reset_mid_write();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
